display_select_sequencer: RTL and testbench

Drives the `Display_Select[5:0]` and `Display_Enable` inputs of the processor's display debug mux. It replaces raw switch selection with a debounced step pushbutton and a timed auto-scan mode, so a demo or test script can walk every debug view in order. The block sits on the board-I/O side, between the DE2 pushbutton/switches and the display mux.

---
 rtl/display_select_sequencer.sv | 113 +++++++++++
 tb/tb_display_select_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_select_sequencer.sv
// display_select_sequencer: debounced step button plus timed auto-scan driving the display debug mux select.
// Define DISPLAY_SEQ_DEBUG_VIEWS_EN to extend the view set with the debug-script views 32..38.
module display_select_sequencer #(
   parameter int DWELL_CYCLES    = 50000000,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 26
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Step_Button,
   input  logic       Mode_Switch,
   input  logic       Direction_Switch,
   input  logic       View_Switch,
   output logic [5:0] Display_Select,
   output logic       Display_Enable,
   output logic       Step_Pulse
);
   typedef enum logic [1:0] {MANUAL, AUTO, PAUSED} state_t;
   localparam logic [CNT_W-1:0] DWELL_LAST    = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
   state_t           state, state_n;
   logic             sync_a, sync_b, btn_level, btn_level_d, press;
   logic [CNT_W-1:0] deb_cnt, dwell_cnt, dwell_n;
   logic [5:0]       fwd_view, bwd_view;
   logic             advance, frozen, live_press;
   // Button path: synchronizer, stable-sample debouncer, registered falling-edge detect.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         sync_a      <= 1'b1;
         sync_b      <= 1'b1;
         btn_level   <= 1'b1;
         btn_level_d <= 1'b1;
         press       <= 1'b0;
         deb_cnt     <= '0;
      end else begin
         sync_a      <= Step_Button;
         sync_b      <= sync_a;
         btn_level_d <= btn_level;
         press       <= btn_level_d & ~btn_level;
         if (sync_b == btn_level)
            deb_cnt <= '0;
         else if (deb_cnt == DEBOUNCE_LAST) begin
            btn_level <= sync_b;
            deb_cnt   <= '0;
         end else
            deb_cnt <= deb_cnt + CNT_ONE;
      end
   end
   always_comb begin
`ifdef DISPLAY_SEQ_DEBUG_VIEWS_EN
      fwd_view = (Display_Select == 6'd26) ? 6'd32 : (Display_Select == 6'd38) ? 6'd0 : Display_Select + 6'd1;
      bwd_view = (Display_Select == 6'd0) ? 6'd38 : (Display_Select == 6'd32) ? 6'd26 : Display_Select - 6'd1;
`else
      fwd_view = (Display_Select == 6'd26) ? 6'd0 : Display_Select + 6'd1;
      bwd_view = (Display_Select == 6'd0) ? 6'd26 : Display_Select - 6'd1;
`endif
   end
   // Mode changes always win; everything else is suppressed while the register view is frozen.
   always_comb begin
      state_n    = state;
      dwell_n    = dwell_cnt;
      advance    = 1'b0;
      frozen     = Display_Enable;
      live_press = press & ~frozen;
      case (state)
         MANUAL: begin
            if (Mode_Switch) begin
               state_n = AUTO;
               dwell_n = '0;
            end else
               advance = live_press;
         end
         AUTO: begin
            if (!Mode_Switch)
               state_n = MANUAL;
            else if (frozen)
               dwell_n = dwell_cnt;
            else if (press)
               state_n = PAUSED;
            else if (dwell_cnt == DWELL_LAST) begin
               advance = 1'b1;
               dwell_n = '0;
            end else
               dwell_n = dwell_cnt + CNT_ONE;
         end
         PAUSED: begin
            if (!Mode_Switch)
               state_n = MANUAL;
            else if (live_press) begin
               state_n = AUTO;
               dwell_n = '0;
            end
         end
         default: state_n = MANUAL;
      endcase
   end
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state          <= MANUAL;
         dwell_cnt      <= '0;
         Display_Select <= 6'd0;
         Display_Enable <= 1'b0;
         Step_Pulse     <= 1'b0;
      end else begin
         state          <= state_n;
         dwell_cnt      <= dwell_n;
         Display_Enable <= View_Switch;
         Step_Pulse     <= advance;
         Display_Select <= advance ? (Direction_Switch ? bwd_view : fwd_view) : Display_Select;
      end
   end
endmodule

// File: tb/tb_display_select_sequencer.sv
// tb_display_select_sequencer: vector table, hand-written corner sequences and a randomized run
// against a view-list/countdown reference model.
module tb_display_select_sequencer;
   localparam int DW  = 8;
   localparam int DB  = 4;
   localparam int LAT = DB + 3;
`ifdef DISPLAY_SEQ_DEBUG_VIEWS_EN
   localparam int NV = 34;
   localparam int WB = 38;
`else
   localparam int NV = 27;
   localparam int WB = 26;
`endif
   typedef struct {
      bit d;
      int low;
      int exp_sel;
      bit exp_pulse;
   } vec_t;
   logic       clk = 1'b0;
   logic       rst, btn, mode, dir, view;
   logic [5:0] sel;
   logic       en, pulse;
   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         views[NV];
   int         pq[$];
   int         m_idx = 0, m_state = 0, m_rem = DW;
   bit         m_en = 1'b0, m_adv = 1'b0;
   always #5 clk = ~clk;
   display_select_sequencer #(.DWELL_CYCLES(DW), .DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut (
      .Clock(clk), .Reset(rst), .Step_Button(btn), .Mode_Switch(mode),
      .Direction_Switch(dir), .View_Switch(view), .Display_Select(sel),
      .Display_Enable(en), .Step_Pulse(pulse)
   );
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask
   // Model: position in the ordered view list; auto mode as a countdown to the next advance.
   task automatic model_step();
      bit pr;
      pr    = 1'b0;
      m_adv = 1'b0;
      while (pq.size() > 0 && pq[0] < cyc) void'(pq.pop_front());
      if (pq.size() > 0 && pq[0] == cyc) begin
         pr = 1'b1;
         void'(pq.pop_front());
      end
      if (rst) begin
         m_idx = 0; m_state = 0; m_rem = DW; m_en = 1'b0;
         pq.delete();
      end else begin
         if (mode != (m_state != 0)) begin
            m_state = mode ? 1 : 0;
            m_rem   = DW;
         end else if (!m_en) begin
            if (m_state == 0 && pr) m_adv = 1'b1;
            else if (m_state == 1 && pr) m_state = 2;
            else if (m_state == 1) begin
               m_rem--;
               if (m_rem == 0) begin
                  m_adv = 1'b1;
                  m_rem = DW;
               end
            end else if (m_state == 2 && pr) begin
               m_state = 1;
               m_rem   = DW;
            end
         end
         if (m_adv) m_idx = dir ? (m_idx + NV - 1) % NV : (m_idx + 1) % NV;
         m_en = view;
      end
   endtask
   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step();
      #1;
   endtask
   task automatic press_step();
      btn = 1'b0;
      repeat (DB) tick();
      btn = 1'b1;
      repeat (DB + 6) tick();
   endtask
   task automatic rtick();
      tick();
      check("rnd_sel", sel, views[m_idx]);
      check("rnd_pulse", pulse, m_adv);
      check("rnd_en", en, m_en);
      if ($urandom_range(0, 59) == 0) mode = ~mode;
      if ($urandom_range(0, 11) == 0) dir = ~dir;
      if ($urandom_range(0, 39) == 0) view = ~view;
   endtask
   initial begin
      vec_t vt[8];
      int   prev;
      for (int i = 0; i < 27; i++) views[i] = i;
      for (int i = 27; i < NV; i++) views[i] = i + 5;
      vt = '{'{1'b0, 6, 1, 1'b1}, '{1'b0, 2, 1, 1'b0}, '{1'b0, 3, 1, 1'b0}, '{1'b0, 4, 2, 1'b1},
             '{1'b1, 5, 1, 1'b1}, '{1'b1, 7, 0, 1'b1}, '{1'b1, 4, WB, 1'b1}, '{1'b0, 6, 0, 1'b1}};
      rst = 1'b1; btn = 1'b1; mode = 1'b0; dir = 1'b0; view = 1'b0;
      tick();
      tick();
      check("reset_sel", sel, 0);
      check("reset_en", en, 0);
      check("reset_pulse", pulse, 0);
      rst = 1'b0;
      tick();
      // Manual presses and short bounces: result lands exactly LAT+1 edges after the drive point.
      prev = 0;
      foreach (vt[i]) begin
         dir = vt[i].d;
         btn = 1'b0;
         for (int k = 1; k <= LAT + 2; k++) begin
            if (k > vt[i].low) btn = 1'b1;
            tick();
            if (k == LAT) check("tv_before_sel", sel, prev);
            if (k == LAT) check("tv_before_pulse", pulse, 0);
            if (k == LAT + 1) check("tv_sel", sel, vt[i].exp_sel);
            if (k == LAT + 1) check("tv_pulse", pulse, vt[i].exp_pulse);
         end
         check("tv_pulse_width", pulse, 0);
         repeat (DB + 6) tick();
         prev = vt[i].exp_sel;
      end
      // Auto wrap starting at 26.
      dir = 1'b0;
      repeat (26) press_step();
      check("aw_start", sel, 26);
      mode = 1'b1;
      tick();
      repeat (DW - 1) tick();
      check("aw_hold", sel, 26);
      for (int j = 1; j <= NV - 26; j++) begin
         if (j > 1) repeat (DW - 1) tick();
         tick();
         check("aw_sel", sel, views[(26 + j) % NV]);
         check("aw_pulse", pulse, 1);
      end
      // Backward wrap, then a press landing on the dwell-expiry edge pauses.
      dir = 1'b1;
      repeat (DW) tick();
      check("bw_wrap", sel, WB);
      btn = 1'b0;
      for (int k = 1; k <= LAT + 1; k++) begin
         if (k > DB) btn = 1'b1;
         tick();
      end
      check("pause_sel", sel, WB);
      check("pause_pulse", pulse, 0);
      repeat (20) tick();
      check("pause_hold", sel, WB);
      btn = 1'b0;
      for (int k = 1; k <= LAT + DW; k++) begin
         if (k > DB) btn = 1'b1;
         tick();
      end
      check("resume_hold", sel, WB);
      tick();
      check("resume_sel", sel, WB - 1);
      check("resume_pulse", pulse, 1);
      // Freeze mid-dwell: four dwell counts consumed before, four remain after.
      repeat (3) tick();
      view = 1'b1;
      tick();
      check("frz_en", en, 1);
      repeat (5) tick();
      btn = 1'b0;
      repeat (DB + 1) tick();
      btn = 1'b1;
      repeat (24) tick();
      check("frz_hold", sel, WB - 1);
      view = 1'b0;
      tick();
      check("frz_en_off", en, 0);
      repeat (3) tick();
      check("frz_remain_hold", sel, WB - 1);
      tick();
      check("frz_resume_sel", sel, WB - 2);
      check("frz_resume_pulse", pulse, 1);
      // Reset mid-dwell discards dwell progress.
      repeat (5) tick();
      rst = 1'b1; dir = 1'b0;
      tick();
      rst = 1'b0;
      check("rst_dwell_sel", sel, 0);
      repeat (DW) tick();
      check("rst_dwell_hold", sel, 0);
      tick();
      check("rst_dwell_adv", sel, 1);
      // Reset mid-debounce restarts the press latency.
      mode = 1'b0;
      tick();
      btn = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_deb_sel", sel, 0);
      repeat (LAT) tick();
      check("rst_deb_hold", sel, 0);
      tick();
      check("rst_deb_sel_adv", sel, 1);
      check("rst_deb_pulse", pulse, 1);
      btn = 1'b1;
      repeat (DB + 6) tick();
      // Randomized run against the model.
      rst = 1'b1; mode = 1'b0; dir = 1'b0; view = 1'b0;
      tick();
      rst = 1'b0;
      repeat (150) begin
         bit full;
         int low, gap;
         full = ($urandom_range(0, 2) != 0);
         low  = full ? $urandom_range(DB, DB + 5) : $urandom_range(1, DB - 1);
         gap  = full ? $urandom_range(DB + 3, DB + 12) : $urandom_range(1, 8);
         if (full) pq.push_back(cyc + 1 + LAT);
         btn = 1'b0;
         repeat (low) rtick();
         btn = 1'b1;
         repeat (gap) rtick();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
